rv_fetch_buffer: RTL and testbench
==================================

# rv_fetch_buffer

Parametrised instruction prefetch queue between the core's bus port and its control sequencer. It replaces the one-shot fetch-into-IR sequence with a decoupled stream: sequential fetch requests are issued ahead of execution, and in-order responses are buffered in a FIFO of configurable depth. The core pops the queue as {pc, inst, fault} tuples. The core flushes the queue and redirects fetch on every taken branch, jump, trap or mret.

## Interface
- `Width`, default 32: address and instruction width.
- `Depth`, default 4: queue entries; power of two, ≥2.
- `MaxOutstanding`, default 2: maximum accepted but unanswered bus requests; ≥1, ≤`Depth`.
- `ResetVector`, default 32'h0000_0000: first fetch address after reset.

Ports:
- `clk` in 1: clock; all state on rising edge.
- `rst` in 1: reset; asynchronous, active-high.
- `req_valid` out 1: fetch request valid.
- `req_ready` in 1: bus accepts request.
- `req_addr` out `Width`: word-aligned fetch address.
- `resp_valid` in 1: bus returns data for the oldest outstanding request.
- `resp_data` in `Width`: instruction word.
- `resp_fault` in 1: bus error for that request.
- `deq_valid` out 1: head entry available.
- `deq_ready` in 1: core consumes head.
- `deq_pc` out `Width`: address of head instruction.
- `deq_inst` out `Width`: head instruction.
- `deq_fault` out 1: head fetch faulted.
- `flush` in 1: discard queue and in-flight fetches.
- `flush_pc` in `Width`: new fetch address; bits [1:0] ignored, treated as 0.

## Operation
- State: `fetch_pc`, `outstanding` counter, `discard` counter, FIFO (rd/wr pointers plus count, `$clog2(Depth)+1` bits), and a `stopped` flag.
- Issue rule: `req_valid` = !`rst` && !`flush` && !`stopped` && `outstanding` < `MaxOutstanding` && (`count` + `outstanding`) < `Depth`. This guarantees a slot for every response.
- `req_addr` = `fetch_pc`. On `req_valid && req_ready`: `fetch_pc` += 4 (wraps modulo 2^`Width`), and `outstanding`++.
- Response handling: `outstanding` decrements on each response.
  - If `discard` > 0, the response is dropped and `discard` decrements.
  - Otherwise {`fetch_pc` of that request, `resp_data`, `resp_fault`} is pushed. The PC is tracked in a parallel `MaxOutstanding`-deep in-flight PC queue.
- Fault: a pushed entry with `resp_fault`=1 sets `stopped`. No further requests are issued until `flush`. The faulting entry is still delivered.
- Dequeue: the head pops on `deq_valid && deq_ready`.
- Flush, effective in the cycle asserted:
  - Queue emptied; `deq_valid` forced 0 that cycle, so a dequeue in that cycle is ignored.
  - `fetch_pc` ← {`flush_pc`[`Width`-1:2], 2'b00}; `stopped` ← 0.
  - `discard` ← `outstanding` minus any response arriving that same cycle. A same-cycle response is always dropped.
  - No request is issued that cycle.
- Simultaneous push and pop on a full queue is legal; the full condition never blocks a response because of the credit rule.
- A `resp_valid` with `outstanding`=0 is a protocol violation; the assertion fires and the response is ignored.

## Timing
- Reset values: `req_valid`=0 while `rst` is high, `req_addr`=`ResetVector`, `deq_valid`=0, `deq_pc`/`deq_inst`=0, `deq_fault`=0. Counters are 0 and `stopped`=0.
- First request: the first cycle after `rst` deasserts.
- Latency: a response in cycle N appears on `deq_*` in cycle N+1 (registered FIFO). See Configuration for bypass.
- Throughput: one instruction per cycle sustained when bus response latency ≤ `MaxOutstanding` cycles.
- After a flush in cycle N, the first request is in cycle N+1 at the new PC.
- Reset mid-operation clears everything immediately. In-flight bus responses after reset are the bus's responsibility, since the bus is reset too.

## Configuration
- `RV_FETCH_BUFFER_BYPASS_EN` defined:
  - When the queue is empty, `discard`=0, `flush`=0 and `resp_valid`=1, the response drives `deq_*` combinationally with `deq_valid`=1 in cycle N.
  - If `deq_ready`=1 the entry is consumed without being written; otherwise it is written normally.
- Undefined: no combinational path from `resp_*` to `deq_*`; latency is strictly N+1.

## Test plan
- Reset release, bus always ready, 1-cycle response with data = address → `deq_pc` sequence 0x0, 0x4, 0x8…, each `deq_inst` equal to its `deq_pc`, one per cycle after fill.
- `deq_ready`=0 held → exactly `Depth` (4) entries fetched, then `req_valid` stays 0; count stays 4 and no overflow.
- With 2 requests outstanding, `flush`=1, `flush_pc`=0x1003 → both late responses dropped; next `req_addr`=0x1000; first `deq_pc`=0x1000.
- Response with `resp_fault`=1 for 0x8 → entry delivered with `deq_fault`=1, no further requests; a later `flush` to 0x40 resumes fetch at 0x40.
- `fetch_pc`=0xFFFF_FFFC → next `req_addr` wraps to 0x0.
- With bypass defined, empty queue, `deq_ready`=1, response in cycle N → `deq_valid`=1 in cycle N and count stays 0; without bypass → `deq_valid` first in N+1.

Source files
------------

// File: rtl/rv_fetch_buffer.sv
// Instruction prefetch queue: issues sequential fetches ahead of execution and buffers in-order
// responses as {pc, inst, fault}. Define RV_FETCH_BUFFER_BYPASS_EN for a same-cycle empty-queue bypass.
module rv_fetch_buffer #(
   parameter int unsigned      Width          = 32,
   parameter int unsigned      Depth          = 4,
   parameter int unsigned      MaxOutstanding = 2,
   parameter logic [Width-1:0] ResetVector    = '0
) (
   input  logic             clk,
   input  logic             rst,
   output logic             req_valid,
   input  logic             req_ready,
   output logic [Width-1:0] req_addr,
   input  logic             resp_valid,
   input  logic [Width-1:0] resp_data,
   input  logic             resp_fault,
   output logic             deq_valid,
   input  logic             deq_ready,
   output logic [Width-1:0] deq_pc,
   output logic [Width-1:0] deq_inst,
   output logic             deq_fault,
   input  logic             flush,
   input  logic [Width-1:0] flush_pc
);
   localparam int unsigned PW = $clog2(Depth);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned OW = $clog2(MaxOutstanding + 1);
   localparam int unsigned IW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
   localparam int unsigned SW = CW + OW;

   typedef struct packed {
      logic [Width-1:0] pc;
      logic [Width-1:0] inst;
      logic             fault;
   } entry_t;

   entry_t           mem [Depth];
   logic [PW-1:0]    rd_ptr, wr_ptr;
   logic [CW-1:0]    count;
   logic [Width-1:0] fetch_pc;
   logic [OW-1:0]    outstanding, discard;
   logic             stopped;

   // Addresses of accepted-but-unanswered requests, oldest at pc_rd.
   logic [Width-1:0] pc_q [MaxOutstanding];
   logic [IW-1:0]    pc_rd, pc_wr;

   logic             req_fire, resp_ok, resp_keep, push, pop, byp_take;
   logic [SW-1:0]    credit;
   entry_t           resp_entry, head, deq_src;
   logic             unused_flush_lsb;

   function automatic logic [IW-1:0] inc_ptr(input logic [IW-1:0] p);
      return (p == IW'(MaxOutstanding - 1)) ? '0 : p + IW'(1);
   endfunction

   // Every issued request already owns a queue slot, so a response can never overflow.
   assign credit    = SW'(count) + SW'(outstanding);
   assign req_valid = !rst && !flush && !stopped &&
                      (outstanding < OW'(MaxOutstanding)) && (credit < SW'(Depth));
   assign req_addr  = fetch_pc;
   assign req_fire  = req_valid && req_ready;

   assign resp_ok    = resp_valid && (outstanding != '0);
   assign resp_keep  = resp_ok && (discard == '0) && !flush;
   assign resp_entry = '{pc: pc_q[pc_rd], inst: resp_data, fault: resp_fault};
   assign head       = mem[rd_ptr];

`ifdef RV_FETCH_BUFFER_BYPASS_EN
   logic byp;
   assign byp       = resp_keep && (count == '0);
   assign byp_take  = byp && deq_ready;
   assign deq_valid = ((count != '0) || byp) && !flush;
   assign deq_src   = (count == '0) ? resp_entry : head;
`else
   assign byp_take  = 1'b0;
   assign deq_valid = (count != '0) && !flush;
   assign deq_src   = head;
`endif

   assign push = resp_keep && !byp_take;
   assign pop  = deq_valid && deq_ready && (count != '0);

   assign deq_pc    = deq_valid ? deq_src.pc    : '0;
   assign deq_inst  = deq_valid ? deq_src.inst  : '0;
   assign deq_fault = deq_valid ? deq_src.fault : 1'b0;

   assign unused_flush_lsb = ^flush_pc[1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc    <= ResetVector;
         outstanding <= '0;
         discard     <= '0;
         stopped     <= 1'b0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         pc_rd       <= '0;
         pc_wr       <= '0;
      end else begin
         outstanding <= outstanding + OW'(req_fire) - OW'(resp_ok);
         if (req_fire) begin
            fetch_pc <= fetch_pc + Width'(4);
            pc_wr    <= inc_ptr(pc_wr);
         end
         // Discarded responses still retire their in-flight PC to keep the queue aligned.
         if (resp_ok)
            pc_rd <= inc_ptr(pc_rd);
         if (flush) begin
            fetch_pc <= {flush_pc[Width-1:2], 2'b00};
            stopped  <= 1'b0;
            discard  <= outstanding - OW'(resp_ok);
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
         end else begin
            if (resp_ok && (discard != '0))
               discard <= discard - OW'(1);
            if (resp_keep && resp_fault)
               stopped <= 1'b1;
            if (push)
               wr_ptr <= wr_ptr + PW'(1);
            if (pop)
               rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= resp_entry;
      if (req_fire)
         pc_q[pc_wr] <= fetch_pc;
   end

`ifndef SYNTHESIS
   a_resp_has_request: assert property (@(posedge clk) disable iff (rst)
      resp_valid |-> (outstanding != '0));
`endif

endmodule

// File: tb/tb_rv_fetch_buffer.sv
// Directed bench for rv_fetch_buffer: hand-traced bus responses, checked once per cycle mid-period.
module tb_rv_fetch_buffer;
   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready;
   logic [31:0] req_addr;
   logic        resp_valid, resp_fault;
   logic [31:0] resp_data;
   logic        deq_valid, deq_ready, deq_fault;
   logic [31:0] deq_pc, deq_inst;
   logic        flush;
   logic [31:0] flush_pc;

   int vectors    = 0;
   int miscompares = 0;

`ifdef RV_FETCH_BUFFER_BYPASS_EN
   localparam int BYP = 1;
`else
   localparam int BYP = 0;
`endif

   rv_fetch_buffer dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .resp_valid(resp_valid), .resp_data(resp_data), .resp_fault(resp_fault),
      .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_pc(deq_pc),
      .deq_inst(deq_inst), .deq_fault(deq_fault),
      .flush(flush), .flush_pc(flush_pc)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive one cycle's inputs just after the edge; checks follow at mid-cycle.
   task automatic drive(input logic rr, input logic rv, input logic [31:0] rd, input logic rf,
                        input logic dr, input logic fl, input logic [31:0] fp);
      req_ready = rr; resp_valid = rv; resp_data = rd; resp_fault = rf;
      deq_ready = dr; flush = fl; flush_pc = fp;
      #4;
   endtask

   task automatic next_cycle();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0);
      next_cycle();
      rst = 1'b0;
   endtask

   initial begin
      // reset state
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0);
      check("rst_req_valid", req_valid, 0);
      check("rst_req_addr",  req_addr,  32'h0);
      check("rst_deq_valid", deq_valid, 0);
      check("rst_deq_pc",    deq_pc,    32'h0);
      check("rst_deq_inst",  deq_inst,  32'h0);
      check("rst_deq_fault", deq_fault, 0);
      next_cycle();
      rst = 1'b0;

      // streaming: 1-cycle responses with data = address, core always ready
      for (int k = 0; k < 8; k++) begin
         drive(1, k > 0, 32'(4 * (k - 1)), 0, 1, 0, 0);
         check($sformatf("stream_req_valid_%0d", k), req_valid, 1);
         check($sformatf("stream_req_addr_%0d", k),  req_addr,  32'(4 * k));
         check($sformatf("stream_deq_valid_%0d", k), deq_valid, 32'(k >= 2 - BYP));
         check($sformatf("stream_deq_pc_%0d", k),    deq_pc,
               (k >= 2 - BYP) ? 32'(4 * (k - 2 + BYP)) : 32'h0);
         check($sformatf("stream_deq_inst_%0d", k),  deq_inst,
               (k >= 2 - BYP) ? 32'(4 * (k - 2 + BYP)) : 32'h0);
         next_cycle();
      end

      // core stalled: queue fills to Depth, then requests stop
      do_reset();
      drive(1, 0, 0,      0, 0, 0, 0); next_cycle();
      drive(1, 1, 32'h0,  0, 0, 0, 0); next_cycle();
      drive(1, 1, 32'h4,  0, 0, 0, 0); next_cycle();
      drive(1, 1, 32'h8,  0, 0, 0, 0);
      check("full_req_addr_c3", req_addr, 32'hC);
      next_cycle();
      drive(1, 1, 32'hC,  0, 0, 0, 0);
      check("full_req_valid_c4", req_valid, 0);
      next_cycle();
      drive(1, 0, 0, 0, 0, 0, 0);
      check("full_req_valid_c5", req_valid, 0);
      check("full_deq_valid_c5", deq_valid, 1);
      check("full_deq_pc_c5",    deq_pc,    32'h0);
      next_cycle();
      for (int k = 0; k < 4; k++) begin
         drive(0, 0, 0, 0, 1, 0, 0);
         check($sformatf("drain_deq_valid_%0d", k), deq_valid, 1);
         check($sformatf("drain_deq_pc_%0d", k),    deq_pc,   32'(4 * k));
         check($sformatf("drain_deq_inst_%0d", k),  deq_inst, 32'(4 * k));
         next_cycle();
      end
      drive(0, 0, 0, 0, 1, 0, 0);
      check("drain_empty", deq_valid, 0);
      check("drain_req_valid", req_valid, 1);
      next_cycle();

      // flush with two requests in flight: late responses dropped
      do_reset();
      drive(1, 0, 0, 0, 1, 0, 0); next_cycle();
      drive(1, 0, 0, 0, 1, 0, 0);
      check("fl_req_addr_c1", req_addr, 32'h4);
      next_cycle();
      drive(1, 0, 0, 0, 1, 0, 0);
      check("fl_limit_c2", req_valid, 0);
      next_cycle();
      drive(1, 0, 0, 0, 1, 1, 32'h1003);
      check("fl_req_valid_flush", req_valid, 0);
      check("fl_deq_valid_flush", deq_valid, 0);
      next_cycle();
      drive(1, 1, 32'hDEAD0000, 0, 1, 0, 0);
      check("fl_req_valid_c4", req_valid, 0);
      check("fl_drop1_deq", deq_valid, 0);
      next_cycle();
      drive(1, 1, 32'hDEAD0004, 0, 1, 0, 0);
      check("fl_req_valid_c5", req_valid, 1);
      check("fl_req_addr_c5",  req_addr,  32'h1000);
      check("fl_drop2_deq",    deq_valid, 0);
      next_cycle();
      drive(0, 1, 32'h1111, 0, 1, 0, 0);
      check("fl_next_addr", req_addr, 32'h1004);
      check("fl_first_valid_n",  deq_valid, 32'(BYP));
      check("fl_first_pc_n",     deq_pc,    BYP ? 32'h1000 : 32'h0);
      next_cycle();
      drive(0, 0, 0, 0, 1, 0, 0);
      check("fl_first_valid_n1", deq_valid, 32'(1 - BYP));
      check("fl_first_pc_n1",    deq_pc,    BYP ? 32'h0 : 32'h1000);
      check("fl_first_inst_n1",  deq_inst,  BYP ? 32'h0 : 32'h1111);
      next_cycle();
      // flush coinciding with the only outstanding response
      drive(1, 0, 0, 0, 1, 0, 0); next_cycle();
      drive(1, 1, 32'h0BAD, 0, 1, 1, 32'h2000);
      check("flsame_req_valid", req_valid, 0);
      next_cycle();
      drive(1, 0, 0, 0, 1, 0, 0);
      check("flsame_req_addr", req_addr, 32'h2000);
      check("flsame_dropped",  deq_valid, 0);
      next_cycle();
      drive(0, 1, 32'h2222, 0, 1, 0, 0);
      check("flsame_valid_n", deq_valid, 32'(BYP));
      next_cycle();
      drive(0, 0, 0, 0, 1, 0, 0);
      check("flsame_valid_n1", deq_valid, 32'(1 - BYP));
      check("flsame_inst_n1",  deq_inst,  BYP ? 32'h0 : 32'h2222);
      next_cycle();

      // fault on 0x8 stops fetch; entry still delivered; flush resumes
      do_reset();
      drive(1, 0, 0,     0, 0, 0, 0); next_cycle();
      drive(1, 1, 32'h0, 0, 0, 0, 0); next_cycle();
      drive(1, 1, 32'h4, 0, 0, 0, 0); next_cycle();
      drive(1, 1, 32'h8, 1, 0, 0, 0);
      check("flt_req_addr_c3", req_addr, 32'hC);
      next_cycle();
      drive(1, 1, 32'hC, 0, 0, 0, 0);
      check("flt_stopped_c4", req_valid, 0);
      next_cycle();
      for (int k = 0; k < 4; k++) begin
         drive(1, 0, 0, 0, 1, 0, 0);
         check($sformatf("flt_req_valid_%0d", k), req_valid, 0);
         check($sformatf("flt_deq_pc_%0d", k),    deq_pc,    32'(4 * k));
         check($sformatf("flt_deq_fault_%0d", k), deq_fault, 32'(k == 2));
         next_cycle();
      end
      drive(1, 0, 0, 0, 1, 0, 0);
      check("flt_empty",       deq_valid, 0);
      check("flt_still_stopped", req_valid, 0);
      next_cycle();
      drive(0, 0, 0, 0, 1, 1, 32'h40);
      check("flt_flush_req_valid", req_valid, 0);
      next_cycle();
      drive(0, 0, 0, 0, 1, 0, 0);
      check("flt_resume_valid", req_valid, 1);
      check("flt_resume_addr",  req_addr,  32'h40);
      next_cycle();

      // address wrap at the top of the address space
      drive(0, 0, 0, 0, 1, 1, 32'hFFFF_FFFF); next_cycle();
      drive(1, 0, 0, 0, 1, 0, 0);
      check("wrap_addr_top", req_addr, 32'hFFFF_FFFC);
      next_cycle();
      drive(1, 0, 0, 0, 1, 0, 0);
      check("wrap_req_valid", req_valid, 1);
      check("wrap_addr_zero", req_addr,  32'h0);
      next_cycle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
